iter_muldiv: RTL and testbench
==============================

Name: iter_muldiv

Overview:
- Iterative multiply/divide unit in the Execute stage, in parallel with the ALU.
- Produces a result and NZCV flags. Those flags feed the condition-logic stage through the same ALUFlags path the ALU uses.
- Multi-cycle operation: raises a stall request so the hazard unit freezes Fetch/Decode/Execute until the result is ready.
- Radix-2 algorithms: shift-add multiply, restoring divide. One bit per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 4.
- CNTW, $clog2(WIDTH)+1, iteration counter width; derived, never overridden.

Ports:
- CLK  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous active-high reset.
- StartE  in  1  launch request; sampled only in IDLE.
- OpE  in  2  00 MUL (low word), 01 UMULH (high word, unsigned), 10 UDIV (quotient), 11 UREM (remainder).
- SrcAE  in  WIDTH  multiplicand / dividend.
- SrcBE  in  WIDTH  multiplier / divisor.
- FlushE  in  1  Execute flush; aborts any operation in progress.
- Busy  out  1  high in RUN or DONE state.
- StallReq  out  1  (StartE & IDLE & ~FlushE) | RUN.
- Done  out  1  one-cycle pulse; ResultE and MDFlags are valid on this cycle.
- ResultE  out  WIDTH  registered result.
- MDFlags  out  4  {N,Z,C,V} for ResultE.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - Busy=0, Done=0, ResultE=0, MDFlags=4'b0100 (Z=1 because the result is 0).
  - Counter, operand registers and accumulator are cleared.
  - Reset mid-operation discards all work; no Done is produced.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - If StartE & ~FlushE: latch OpE, SrcAE and SrcBE; counter=WIDTH.
  - Accumulator/remainder are cleared.
  - Go to RUN, except UDIV/UREM with SrcBE==0, which go directly to DONE.
- RUN: one iteration per cycle; counter decrements; when counter reaches 1 the next state is DONE.
  - Multiply: 2*WIDTH-bit product built by shift-add. Each iteration adds the multiplicand if multiplier LSB=1, then shifts right. Unsigned throughout.
  - Divide: restoring algorithm, quotient bit per cycle MSB-first. Remainder is WIDTH+1 bits internally, so no overflow is possible.
- DONE:
  - Done=1 for exactly one cycle; ResultE/MDFlags update on the clock edge entering DONE.
  - Next state is IDLE. StartE in DONE is ignored; a new op may launch the cycle after DONE.
- Results:
  - MUL: product[WIDTH-1:0].
  - UMULH: product[2*WIDTH-1:WIDTH].
  - UDIV: quotient.
  - UREM: remainder[WIDTH-1:0].
- Divide by zero: UDIV result is all ones, UREM result is SrcAE. Done occurs 1 cycle after launch.
- Latency:
  - Normal op: launch cycle at edge t; Done at cycle t+WIDTH+1.
  - StallReq is high from the launch cycle through the last RUN cycle and low in DONE, so the consumer advances on Done.
- Flags:
  - N=ResultE[WIDTH-1].
  - Z=(ResultE==0).
  - C=0 and V=0 always.
- FlushE:
  - In RUN or DONE: return to IDLE next edge. Done is suppressed; ResultE/MDFlags keep their previous values.
  - Flush in the same cycle as StartE: no launch.
- StartE while in RUN is ignored; operands are not re-latched.
- ResultE/MDFlags hold their value between completions.

Optional Feature:
- Macro MULDIV_EARLY_TERM_EN.
- Defined:
  - A multiply ends RUN as soon as the remaining unshifted multiplier bits are all zero.
  - The product is aligned by a final shift of the remaining count during the DONE transition. Result is identical to full iteration.
  - Multiply by 0 or 1 finishes in 2 cycles, i.e. Done one cycle after launch plus one RUN cycle.
  - Divide behaviour is unchanged.
- Undefined: every multiply takes exactly WIDTH RUN cycles.

Test Plan:
- Reset asserted mid-RUN (MUL 7*6 at cycle 10) -> Busy=0, Done never pulses, ResultE=0, MDFlags=4'b0100 immediately after reset asserts.
- MUL SrcAE=32'd12345, SrcBE=32'd678 -> Done exactly 33 cycles after launch, ResultE=32'd8369910, MDFlags=4'b0000, StallReq high 32 cycles.
- UMULH 32'hFFFFFFFF*32'hFFFFFFFF -> ResultE=32'hFFFFFFFE, N=1. MUL of the same operands -> ResultE=32'h00000001.
- UDIV 100/7 -> ResultE=14; UREM 100/7 -> ResultE=2. UDIV 5/0 -> Done 1 cycle after launch, ResultE=32'hFFFFFFFF, MDFlags=4'b1000.
- FlushE pulsed 5 cycles into a UDIV -> IDLE next cycle, no Done, ResultE unchanged; back-to-back launch afterwards completes correctly.
- With MULDIV_EARLY_TERM_EN: MUL 9*1 -> ResultE=9 with Done 2 cycles after launch. Without the macro: Done at 33 cycles, same ResultE.

Source files
------------

// File: rtl/iter_muldiv.sv
// Iterative radix-2 multiply/divide unit: shift-add MUL/UMULH, restoring UDIV/UREM, one bit per cycle.
// Optional MULDIV_EARLY_TERM_EN ends a multiply once the remaining multiplier bits are all zero.
module iter_muldiv #(
    parameter  int WIDTH = 32,
    localparam int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             StartE,
    input  logic [1:0]       OpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             FlushE,
    output logic             Busy,
    output logic             StallReq,
    output logic             Done,
    output logic [WIDTH-1:0] ResultE,
    output logic [3:0]       MDFlags
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULH = 2'b01;
    localparam logic [1:0] OP_UDIV  = 2'b10;
    localparam logic [1:0] OP_UREM  = 2'b11;

    state_t            state, state_nxt;
    logic [1:0]        op_q;
    logic [WIDTH-1:0]  opa_q;   // multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0]  opb_q;   // multiplier (shifts right), or divisor
    logic [WIDTH-1:0]  acc_q;   // product high word, or partial remainder
    logic [WIDTH-1:0]  lo_q;    // product low word, filled from the top
    logic [CNTW-1:0]   cnt_q;
    logic [WIDTH-1:0]  result_q;
    logic [3:0]        flags_q;

    logic              launch;
    logic              div_zero_launch;
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH-1:0]  mul_hi_n;
    logic [WIDTH-1:0]  mul_lo_n;
    logic [WIDTH-1:0]  mul_b_n;
    logic [2*WIDTH-1:0] prod_n;
    logic [WIDTH:0]    div_sh;
    logic [WIDTH:0]    div_diff;
    logic              div_ge;
    logic [WIDTH-1:0]  div_r_n;
    logic [WIDTH-1:0]  div_q_n;
    logic [CNTW-1:0]   cnt_n;
    logic              last_iter;
    logic [WIDTH-1:0]  res_run;
    logic [WIDTH-1:0]  res_zero_div;

    function automatic logic [3:0] nzcv(input logic [WIDTH-1:0] r);
        return {r[WIDTH-1], (r == '0), 2'b00};
    endfunction

    assign launch          = (state == S_IDLE) && StartE && !FlushE;
    assign div_zero_launch = launch && OpE[1] && (SrcBE == '0);
    assign res_zero_div    = (OpE == OP_UREM) ? SrcAE : '1;

    // Multiply step: conditional add, then shift the whole {carry,hi,lo} right by one.
    assign mul_sum  = {1'b0, acc_q} + (opb_q[0] ? {1'b0, opa_q} : '0);
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    assign mul_b_n  = opb_q >> 1;

    // Restoring divide step; the borrow out of the WIDTH+1-bit subtract decides the quotient bit.
    assign div_sh   = {acc_q, opa_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opb_q};
    assign div_ge   = !div_diff[WIDTH];
    assign div_r_n  = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_q_n  = {opa_q[WIDTH-2:0], div_ge};

    assign cnt_n = cnt_q - CNTW'(1);

`ifdef MULDIV_EARLY_TERM_EN
    // Skipped iterations would only shift, so realign by the remaining count.
    assign last_iter = (cnt_q == CNTW'(1)) || (!op_q[1] && (mul_b_n == '0));
    assign prod_n    = {mul_hi_n, mul_lo_n} >> cnt_n;
`else
    assign last_iter = (cnt_q == CNTW'(1));
    assign prod_n    = {mul_hi_n, mul_lo_n};
`endif

    always_comb begin
        res_run = '0;
        unique case (op_q)
            OP_MUL:   res_run = prod_n[WIDTH-1:0];
            OP_UMULH: res_run = prod_n[2*WIDTH-1:WIDTH];
            OP_UDIV:  res_run = div_q_n;
            OP_UREM:  res_run = div_r_n;
            default:  res_run = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (launch) state_nxt = div_zero_launch ? S_DONE : S_RUN;
            S_RUN: begin
                if (FlushE)         state_nxt = S_IDLE;
                else if (last_iter) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        Busy     = (state == S_RUN) || (state == S_DONE);
        Done     = (state == S_DONE) && !FlushE;
        StallReq = launch || (state == S_RUN);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            op_q     <= OP_MUL;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= 4'b0100;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (launch) begin
                        op_q  <= OpE;
                        opa_q <= SrcAE;
                        opb_q <= SrcBE;
                        acc_q <= '0;
                        lo_q  <= '0;
                        cnt_q <= CNTW'(WIDTH);
                        if (div_zero_launch) begin
                            result_q <= res_zero_div;
                            flags_q  <= nzcv(res_zero_div);
                        end
                    end
                end
                S_RUN: begin
                    if (!FlushE) begin
                        cnt_q <= cnt_n;
                        if (op_q[1]) begin
                            acc_q <= div_r_n;
                            opa_q <= div_q_n;
                        end else begin
                            acc_q <= mul_hi_n;
                            lo_q  <= mul_lo_n;
                            opb_q <= mul_b_n;
                        end
                        if (last_iter) begin
                            result_q <= res_run;
                            flags_q  <= nzcv(res_run);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ResultE = result_q;
    assign MDFlags = flags_q;

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed self-checking bench for iter_muldiv with hand-computed expected results and latencies.
module tb_iter_muldiv;
    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         Reset;
    logic         StartE;
    logic [1:0]   OpE;
    logic [W-1:0] SrcAE;
    logic [W-1:0] SrcBE;
    logic         FlushE;
    logic         Busy;
    logic         StallReq;
    logic         Done;
    logic [W-1:0] ResultE;
    logic [3:0]   MDFlags;

    int n_checks = 0;
    int n_errors = 0;

    iter_muldiv #(.WIDTH(W)) dut (
        .CLK(CLK), .Reset(Reset), .StartE(StartE), .OpE(OpE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .FlushE(FlushE),
        .Busy(Busy), .StallReq(StallReq), .Done(Done),
        .ResultE(ResultE), .MDFlags(MDFlags)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic int mul_lat(input logic [W-1:0] b);
`ifdef MULDIV_EARLY_TERM_EN
        int nb = 1;
        for (int i = 0; i < W; i++) if (b[i]) nb = i + 1;
        return nb + 1;
`else
        return W + 1;
`endif
    endfunction

    // Launch in the current cycle, then count cycles until Done.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res,
                          input logic [3:0] exp_flags, input int exp_lat);
        int lat;
        int stalls;
        OpE    = op;
        SrcAE  = a;
        SrcBE  = b;
        StartE = 1'b1;
        #1;
        check({tag, " launch_stall"}, 64'(StallReq), 64'd1);
        step();
        StartE = 1'b0;
        SrcAE  = ~a;
        SrcBE  = ~b;
        lat    = 1;
        stalls = 0;
        while (Done !== 1'b1 && lat < 100) begin
            if (StallReq) stalls++;
            step();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " stalls"}, 64'(stalls), 64'(exp_lat - 1));
        check({tag, " result"}, 64'(ResultE), 64'(exp_res));
        check({tag, " flags"}, 64'(MDFlags), 64'(exp_flags));
        check({tag, " done_stall"}, 64'(StallReq), 64'd0);
        step();
        check({tag, " idle_busy"}, 64'(Busy), 64'd0);
        check({tag, " done_pulse"}, 64'(Done), 64'd0);
    endtask

    initial begin
        int pulses;
        Reset  = 1'b1;
        StartE = 1'b0;
        FlushE = 1'b0;
        OpE    = 2'b00;
        SrcAE  = '0;
        SrcBE  = '0;
        step();
        step();
        check("rst busy", 64'(Busy), 64'd0);
        check("rst done", 64'(Done), 64'd0);
        check("rst result", 64'(ResultE), 64'd0);
        check("rst flags", 64'(MDFlags), 64'h4);
        Reset = 1'b0;
        step();

        run_op("mul", 2'b00, 32'd12345, 32'd678, 32'd8369910, 4'b0000, mul_lat(32'd678));
        run_op("umulh_ff", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1000,
               mul_lat(32'hFFFFFFFF));
        run_op("mul_ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000,
               mul_lat(32'hFFFFFFFF));
        run_op("mul_9x1", 2'b00, 32'd9, 32'd1, 32'd9, 4'b0000, mul_lat(32'd1));
        run_op("mul_x0", 2'b00, 32'd77, 32'd0, 32'd0, 4'b0100, mul_lat(32'd0));

        // Reset in the middle of a multiply discards it.
        OpE = 2'b00; SrcAE = 32'd7; SrcBE = 32'd6; StartE = 1'b1;
        step();
        StartE = 1'b0;
        for (int i = 0; i < 9; i++) step();
        Reset = 1'b1;
        #1;
        check("midrst busy", 64'(Busy), 64'd0);
        check("midrst done", 64'(Done), 64'd0);
        check("midrst result", 64'(ResultE), 64'd0);
        check("midrst flags", 64'(MDFlags), 64'h4);
        step();
        Reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (Done) pulses++;
        end
        check("midrst no_done", 64'(pulses), 64'd0);

        run_op("udiv", 2'b10, 32'd100, 32'd7, 32'd14, 4'b0000, W + 1);
        run_op("urem", 2'b11, 32'd100, 32'd7, 32'd2, 4'b0000, W + 1);
        run_op("udiv0", 2'b10, 32'd5, 32'd0, 32'hFFFFFFFF, 4'b1000, 1);
        run_op("urem0", 2'b11, 32'd5, 32'd0, 32'd5, 4'b0000, 1);
        run_op("udiv_zero_num", 2'b10, 32'd0, 32'd3, 32'd0, 4'b0100, W + 1);
        run_op("udiv_by1", 2'b10, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 4'b1000, W + 1);
        run_op("udiv_big", 2'b10, 32'hFFFFFFFF, 32'h80000000, 32'd1, 4'b0000, W + 1);

        // Flush five cycles into a divide: no Done, previous result kept.
        OpE = 2'b10; SrcAE = 32'd200; SrcBE = 32'd3; StartE = 1'b1;
        step();
        StartE = 1'b0;
        for (int i = 0; i < 4; i++) step();
        FlushE = 1'b1;
        step();
        FlushE = 1'b0;
        check("flush busy", 64'(Busy), 64'd0);
        check("flush stall", 64'(StallReq), 64'd0);
        check("flush result", 64'(ResultE), 64'd1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done) pulses++;
            step();
        end
        check("flush no_done", 64'(pulses), 64'd0);
        run_op("after_flush", 2'b11, 32'd100, 32'd7, 32'd2, 4'b0000, W + 1);

        // Start together with flush in IDLE does not launch.
        OpE = 2'b00; SrcAE = 32'd3; SrcBE = 32'd3; StartE = 1'b1; FlushE = 1'b1;
        #1;
        check("startflush stall", 64'(StallReq), 64'd0);
        step();
        StartE = 1'b0; FlushE = 1'b0;
        check("startflush busy", 64'(Busy), 64'd0);
        check("startflush result", 64'(ResultE), 64'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
